// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT branch predictor with 2-bit counters and a registered one-cycle redirect.
// Define BP_PERF_EN to add the perf_branches / perf_mispredicts counters.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    logic [ENTRIES-1:0] valid_r;
    logic [TW-1:0]      tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];
    logic [1:0]         ctr_r    [ENTRIES];

    logic [IDX-1:0] if_idx_s;
    logic [IDX-1:0] ex_idx_s;
    logic           if_hit_s;
    logic           ex_hit_s;
    logic           ctl_s;
    logic           taken_eff_s;
    logic           flag_s;
    logic [1:0]     ctr_next_s;
    logic [31:0]    redirect_s;

    // Fetch-side lookup; reads pre-update state so a same-cycle update is seen next cycle
    always_comb begin
        if_idx_s   = if_pc[IDX+1:2];
        if_hit_s   = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_pc[31:IDX+2]);
        pred_taken = if_hit_s && ctr_r[if_idx_s][1];
        if (pred_taken) begin
            pred_target = target_r[if_idx_s];
        end else begin
            pred_target = if_pc + 32'd4;
        end
    end

    // Resolution: mispredict detection, correct next PC and next counter value
    always_comb begin
        ex_idx_s    = ex_pc[IDX+1:2];
        ex_hit_s    = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_pc[31:IDX+2]);
        ctl_s       = ex_is_branch || ex_is_jump;
        taken_eff_s = ex_taken || ex_is_jump;
        flag_s      = 1'b0;
        if (ex_valid && ctl_s) begin
            flag_s = (taken_eff_s != ex_pred_taken) ||
                     (taken_eff_s && (ex_target != ex_pred_target));
        end else if (ex_valid) begin
            // a non-control instruction that was predicted taken aliased onto a BTB entry
            flag_s = ex_pred_taken;
        end else begin
            flag_s = 1'b0;
        end
        if (taken_eff_s) begin
            redirect_s = ex_target;
        end else begin
            redirect_s = ex_pc + 32'd4;
        end
        ctr_next_s = ctr_r[ex_idx_s];
        if (taken_eff_s) begin
            if (ctr_r[ex_idx_s] != 2'b11) begin
                ctr_next_s = ctr_r[ex_idx_s] + 2'd1;
            end else begin
                ctr_next_s = 2'b11;
            end
        end else begin
            if (ctr_r[ex_idx_s] != 2'b00) begin
                ctr_next_s = ctr_r[ex_idx_s] - 2'd1;
            end else begin
                ctr_next_s = 2'b00;
            end
        end
    end

    // Table state: counter training, allocation on taken misses, alias invalidation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
                ctr_r[i]    <= 2'b01;
            end
        end else if (ex_valid && ctl_s) begin
            if (ex_hit_s) begin
                ctr_r[ex_idx_s] <= ctr_next_s;
                if (taken_eff_s) begin
                    target_r[ex_idx_s] <= ex_target;
                end
            end else if (taken_eff_s) begin
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_pc[31:IDX+2];
                target_r[ex_idx_s] <= ex_target;
                ctr_r[ex_idx_s]    <= ex_is_jump ? 2'b11 : 2'b10;
            end
        end else if (ex_valid && ex_pred_taken && ex_hit_s) begin
            valid_r[ex_idx_s] <= 1'b0;
        end
    end

    // Registered redirect pulse; redirect_pc only meaningful while mispredict is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            mispredict <= flag_s;
            if (flag_s) begin
                redirect_pc <= redirect_s;
            end
        end
    end

`ifdef BP_PERF_EN
    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches    <= 32'd0;
            perf_mispredicts <= 32'd0;
        end else begin
            if (ex_valid && ctl_s) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (flag_s) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset corner case,
// and randomized traffic against a behavioural predictor model.
module tb_branch_predictor;
    localparam int ENT = 16;
    localparam int IB  = 4;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(.ENTRIES(ENT)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ev;
        logic        br;
        logic        jp;
        logic        tk;
        logic [31:0] epc;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptgt;
        logic [31:0] ipc;
        logic        x_pt;
        logic [31:0] x_ptgt;
        logic        x_mis;
        logic [31:0] x_redir;
    } vec_t;

    // behavioural model: one slot per index holding the allocating PC
    bit          m_valid [ENT];
    logic [31:0] m_pc    [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic bit mhit(input logic [31:0] pc);
        int i = midx(pc);
        return m_valid[i] && ((m_pc[i] >> (IB + 2)) == (pc >> (IB + 2)));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br  = 32'd0;
        m_mis = 32'd0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        pt  = mhit(pc) && (m_ctr[midx(pc)] >= 2);
        tgt = pt ? m_tgt[midx(pc)] : pc + 32'd4;
    endtask

    task automatic m_expect(inout vec_t v);
        logic ctl = v.br | v.jp;
        logic te  = v.tk | v.jp;
        m_lookup(v.ipc, v.x_pt, v.x_ptgt);
        if (!v.rst || !v.ev) v.x_mis = 1'b0;
        else if (ctl) v.x_mis = (te != v.ept) || (te && (v.etgt != v.eptgt));
        else v.x_mis = v.ept;
        v.x_redir = !v.rst ? 32'd0 : (te ? v.etgt : v.epc + 32'd4);
    endtask

    task automatic m_apply(input vec_t v);
        int  i   = midx(v.epc);
        bit  hit = mhit(v.epc);
        logic ctl = v.br | v.jp;
        logic te  = v.tk | v.jp;
        if (!v.rst) begin
            m_reset();
        end else if (v.ev) begin
            if (ctl) m_br = m_br + 32'd1;
            if (v.x_mis) m_mis = m_mis + 32'd1;
            if (ctl && hit) begin
                m_ctr[i] = te ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
                if (te) m_tgt[i] = v.etgt;
            end else if (ctl && te) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = v.epc;
                m_tgt[i]   = v.etgt;
                m_ctr[i]   = v.jp ? 3 : 2;
            end else if (!ctl && v.ept && hit) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        rst_n = v.rst; ex_valid = v.ev; ex_is_branch = v.br; ex_is_jump = v.jp;
        ex_taken = v.tk; ex_pc = v.epc; ex_target = v.etgt;
        ex_pred_taken = v.ept; ex_pred_target = v.eptgt; if_pc = v.ipc;
        #1;
        chk({nm, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, v.x_pt});
        chk({nm, ".pred_target"}, pred_target, v.x_ptgt);
        @(posedge clk);
        #1;
        chk({nm, ".mispredict"}, {31'd0, mispredict}, {31'd0, v.x_mis});
        if (v.x_mis || !v.rst) chk({nm, ".redirect_pc"}, redirect_pc, v.x_redir);
    endtask

    function automatic logic [31:0] rpc();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + 32'($urandom_range(0, 1)) * 32'h40 + 32'($urandom_range(0, 3)) * 32'd4;
    endfunction

    vec_t tbl [22];
    vec_t v;
    logic [31:0] tgts [4];

    initial begin
        tbl[0]  = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     N, 32'h1004, N, 32'h0};
        tbl[1]  = '{Y, Y, Y, N, Y, 32'h1000,     32'h1100, N, 32'h1004, 32'h1000,     N, 32'h1004, Y, 32'h1100};
        tbl[2]  = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     Y, 32'h1100, N, 32'h0};
        tbl[3]  = '{Y, Y, Y, N, N, 32'h1000,     32'h1100, Y, 32'h1100, 32'h1000,     Y, 32'h1100, Y, 32'h1004};
        tbl[4]  = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     N, 32'h1004, N, 32'h0};
        tbl[5]  = '{Y, Y, Y, N, Y, 32'h1000,     32'h1100, N, 32'h1004, 32'h1000,     N, 32'h1004, Y, 32'h1100};
        tbl[6]  = '{Y, Y, Y, N, Y, 32'h1000,     32'h1100, Y, 32'h1100, 32'h1000,     Y, 32'h1100, N, 32'h0};
        tbl[7]  = '{Y, Y, Y, N, N, 32'h1000,     32'h1100, Y, 32'h1100, 32'h1000,     Y, 32'h1100, Y, 32'h1004};
        tbl[8]  = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     Y, 32'h1100, N, 32'h0};
        tbl[9]  = '{Y, Y, N, Y, N, 32'h2000,     32'h3000, N, 32'h2004, 32'h2000,     N, 32'h2004, Y, 32'h3000};
        tbl[10] = '{Y, Y, N, Y, N, 32'h2000,     32'h3100, Y, 32'h3000, 32'h2000,     Y, 32'h3000, Y, 32'h3100};
        tbl[11] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h2000,     Y, 32'h3100, N, 32'h0};
        tbl[12] = '{Y, Y, N, Y, N, 32'h2000,     32'h3100, Y, 32'h3100, 32'h2000,     Y, 32'h3100, N, 32'h0};
        tbl[13] = '{Y, Y, Y, N, Y, 32'hFFFFFFFC, 32'h4000, N, 32'h0,    32'hFFFFFFFC, N, 32'h0,    Y, 32'h4000};
        tbl[14] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'hFFFFFFFC, Y, 32'h4000, N, 32'h0};
        tbl[15] = '{Y, Y, N, N, N, 32'hFFFFFFFC, 32'h4000, Y, 32'h4000, 32'hFFFFFFFC, Y, 32'h4000, Y, 32'h0};
        tbl[16] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'hFFFFFFFC, N, 32'h0,    N, 32'h0};
        tbl[17] = '{Y, Y, Y, N, N, 32'h1000,     32'h1100, N, 32'h1004, 32'h1000,     N, 32'h1004, N, 32'h0};
        tbl[18] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h2000,     Y, 32'h3100, N, 32'h0};
        tbl[19] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     N, 32'h1004, N, 32'h0};
        tbl[20] = '{Y, N, Y, N, Y, 32'h1000,     32'h5000, N, 32'h1004, 32'h1000,     N, 32'h1004, N, 32'h0};
        tbl[21] = '{Y, N, N, N, N, 32'h0,        32'h0,    N, 32'h0,    32'h1000,     N, 32'h1004, N, 32'h0};
        tgts[0] = 32'h1100; tgts[1] = 32'h3000; tgts[2] = 32'h4000; tgts[3] = 32'h0;

        rst_n = 1'b0; if_pc = 32'h1000; ex_valid = 1'b0; ex_pc = 32'h0;
        ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.mispredict", {31'd0, mispredict}, 32'd0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);

        for (int i = 0; i < 22; i++) run(tbl[i], $sformatf("vec%0d", i));

        // reset asserted together with a mispredicting resolution
        v = '{N, Y, Y, N, Y, 32'h1000, 32'h6000, N, 32'h1004, 32'h2000, Y, 32'h3100, N, 32'h0};
        run(v, "rst_mid");
        m_reset();
`ifdef BP_PERF_EN
        chk("rst_mid.perf_branches", perf_branches, 32'd0);
        chk("rst_mid.perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        v = '{Y, N, N, N, N, 32'h0, 32'h0, N, 32'h0, 32'h2000, N, 32'h2004, N, 32'h0};
        run(v, "rst_mid_a");
        v = '{Y, N, N, N, N, 32'h0, 32'h0, N, 32'h0, 32'h1000, N, 32'h1004, N, 32'h0};
        run(v, "rst_mid_b");
        v = '{Y, N, N, N, N, 32'h0, 32'h0, N, 32'h0, 32'hFFFFFFFC, N, 32'h0, N, 32'h0};
        run(v, "rst_mid_c");

        for (int k = 0; k < 800; k++) begin
            int kind;
            logic mpt;
            logic [31:0] mptgt;
            v.rst  = ($urandom_range(0, 39) != 0);
            v.ev   = ($urandom_range(0, 3) != 0);
            kind   = int'($urandom_range(0, 3));
            v.br   = (kind >= 2);
            v.jp   = (kind == 1);
            v.tk   = v.br ? logic'($urandom_range(0, 1)) : 1'b0;
            v.epc  = rpc();
            v.etgt = tgts[$urandom_range(0, 3)];
            m_lookup(v.epc, mpt, mptgt);
            if ($urandom_range(0, 9) < 7) begin
                v.ept   = mpt;
                v.eptgt = mptgt;
            end else begin
                v.ept   = logic'($urandom_range(0, 1));
                v.eptgt = tgts[$urandom_range(0, 3)];
            end
            v.ipc = ($urandom_range(0, 1) == 0) ? v.epc : rpc();
            m_expect(v);
            run(v, $sformatf("rnd%0d", k));
            m_apply(v);
        end
`ifdef BP_PERF_EN
        chk("rnd.perf_branches", perf_branches, m_br);
        chk("rnd.perf_mispredicts", perf_mispredicts, m_mis);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
